// File: rtl/bti_rom_ctrl.sv
// bti_rom_ctrl: pipelined BTI read front end for a synchronous ROM with in-order buffered responses
module bti_rom_ctrl #(
  parameter int                BTI_AW    = 32,
  parameter int                BTI_DW    = 32,
  parameter int                TIDW      = 4,
  parameter int                ROM_AW    = 15,
  parameter logic [BTI_AW-1:0] BASE      = '0,
  parameter int                RD_LAT    = 1,
  parameter int                RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bti_req_vld,
  output logic              bti_req_rdy,
  input  logic [BTI_AW-1:0] bti_req_addr,
  input  logic [TIDW-1:0]   bti_req_tid,
  output logic              bti_rsp_vld,
  input  logic              bti_rsp_rdy,
  output logic [TIDW-1:0]   bti_rsp_tid,
  output logic [BTI_DW-1:0] bti_rsp_data,
  output logic              bti_rsp_ok,
  output logic              rom_cs,
  output logic [ROM_AW-3:0] rom_addr,
  input  logic [BTI_DW-1:0] rom_data,
  output logic [15:0]       err_cnt
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  logic [CW-1:0]     occ_q, occ_d, cnt_q, cnt_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [RD_LAT-1:0] pv_q, ph_q;
  logic [TIDW-1:0]   pt_q [RD_LAT];
  logic [TIDW-1:0]   ft_q [RSP_DEPTH];
  logic [BTI_DW-1:0] fd_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fo_q;
  logic [15:0]       err_q, err_d;
  logic              acc, hit, wr, pop;
  // occ bounds in-flight plus buffered entries, so the FIFO can never overflow
  always_comb begin
    hit = bti_req_addr[BTI_AW-1:ROM_AW] == BASE[BTI_AW-1:ROM_AW] && bti_req_addr[1:0] == 2'b00;
    bti_req_rdy = !rst && occ_q < CW'(RSP_DEPTH);
    acc = bti_req_vld && bti_req_rdy;
    rom_cs = acc && hit;
    rom_addr = bti_req_addr[ROM_AW-1:2];
    wr = pv_q[RD_LAT-1];
    bti_rsp_vld = !rst && cnt_q != '0;
    pop = bti_rsp_vld && bti_rsp_rdy;
    bti_rsp_tid = bti_rsp_vld ? ft_q[rp_q] : '0;
    bti_rsp_data = bti_rsp_vld ? fd_q[rp_q] : '0;
    bti_rsp_ok = bti_rsp_vld && fo_q[rp_q];
    occ_d = occ_q + CW'(acc) - CW'(pop);
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    wp_d = !wr ? wp_q : wp_q == PW'(RSP_DEPTH - 1) ? '0 : wp_q + PW'(1);
    rp_d = !pop ? rp_q : rp_q == PW'(RSP_DEPTH - 1) ? '0 : rp_q + PW'(1);
    err_d = pop && !bti_rsp_ok && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
    err_cnt = rst ? '0 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      pv_q  <= '0;
      err_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      pv_q  <= RD_LAT'({pv_q, acc});
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    ph_q    <= RD_LAT'({ph_q, hit});
    pt_q[0] <= bti_req_tid;
    for (int i = 1; i < RD_LAT; i++) pt_q[i] <= pt_q[i-1];
    if (wr) begin
      ft_q[wp_q] <= pt_q[RD_LAT-1];
      fd_q[wp_q] <= ph_q[RD_LAT-1] ? rom_data : '0;
      fo_q[wp_q] <= ph_q[RD_LAT-1];
    end
  end
endmodule
